// File: rtl/stopwatch_sequencer.sv
// -----------------------------------------------------------------------------
// stopwatch_sequencer
//
// Control and datapath sequencer for a cascaded BCD stopwatch. A start/pause/
// clear state machine gates a single-cycle tick from the clock-enable divider
// into an N-digit decade cascade. A lap register can freeze the displayed
// value while the live count keeps running underneath.
//
// Ports:
//   clockIn    in   1        system clock, rising-edge active
//   reset      in   1        asynchronous, active-high reset
//   tick       in   1        one-cycle count enable from the divider
//   startStop  in   1        button level, synchronous to clockIn
//   clear      in   1        button level, synchronous to clockIn
//   lap        in   1        button level, synchronous to clockIn
//   display    out  4*N      BCD digits, digit 0 in bits [3:0]
//   running    out  1        high while in RUN
//   lapActive  out  1        high while the frozen lap value is displayed
//   carryOut   out  1        one-cycle pulse after an all-9s to all-0s wrap
// -----------------------------------------------------------------------------
module stopwatch_sequencer #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clockIn,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    startStop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] display,
    output logic                    running,
    output logic                    lapActive,
    output logic                    carryOut
);

    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_lap_reg;
    logic           r_lap_active;
    logic           r_carry;
    logic           r_running;
    logic           r_ss_hist;
    logic           r_clr_hist;
    logic           r_lap_hist;

    logic           w_ss_press;
    logic           w_clr_press;
    logic           w_lap_press;
    logic           w_count_en;
    logic [W-1:0]   w_count_next;
    logic [NUM_DIGITS:0]   w_chain;
    logic [NUM_DIGITS-1:0] w_is9;

    // Rising-edge press detection against last cycle's level.
    assign w_ss_press  = startStop & ~r_ss_hist;
    assign w_clr_press = clear     & ~r_clr_hist;
    assign w_lap_press = lap       & ~r_lap_hist;

    // Only the pre-edge state decides whether a tick counts, so the edge that
    // leaves RUN still counts and the edge that enters RUN does not.
    assign w_count_en = (r_state == ST_RUN) & tick;

    // Decade cascade: w_chain[gi] is high when digit gi must increment, i.e.
    // the tick is qualified and every lower digit is at 9.
    assign w_chain[0] = w_count_en;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] w_digit;
            assign w_digit = r_count[gi*4 +: 4];
            assign w_is9[gi] = (w_digit == 4'd9);
            assign w_chain[gi+1] = w_chain[gi] & w_is9[gi];
            assign w_count_next[gi*4 +: 4] =
                w_chain[gi] ? (w_is9[gi] ? 4'd0 : w_digit + 4'd1) : w_digit;
        end
    endgenerate

    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_lap_reg    <= '0;
            r_lap_active <= 1'b0;
            r_carry      <= 1'b0;
            r_running    <= 1'b0;
            // Histories start high so a button held through reset release
            // is not seen as a press.
            r_ss_hist    <= 1'b1;
            r_clr_hist   <= 1'b1;
            r_lap_hist   <= 1'b1;
        end else begin
            r_ss_hist  <= startStop;
            r_clr_hist <= clear;
            r_lap_hist <= lap;

            r_count <= w_count_next;
            // Carry out of the top digit means every digit was 9.
            r_carry <= w_chain[NUM_DIGITS];

            case (r_state)
                ST_IDLE: begin
                    if (w_ss_press) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // clear is not valid here, so startStop outranks lap.
                    if (w_ss_press) begin
                        r_state   <= ST_PAUSE;
                        r_running <= 1'b0;
                    end else if (w_lap_press) begin
                        if (!r_lap_active) begin
                            // Capture the pre-edge count; a same-edge tick
                            // only shows up in the live count.
                            r_lap_reg    <= r_count;
                            r_lap_active <= 1'b1;
                        end else begin
                            r_lap_active <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_clr_press) begin
                        r_state      <= ST_IDLE;
                        r_running    <= 1'b0;
                        r_count      <= '0;
                        r_lap_reg    <= '0;
                        r_lap_active <= 1'b0;
                    end else if (w_ss_press) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else if (w_lap_press) begin
                        r_lap_active <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign display   = r_lap_active ? r_lap_reg : r_count;
    assign running   = r_running;
    assign lapActive = r_lap_active;
    assign carryOut  = r_carry;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
module tb_stopwatch_sequencer;

    localparam int ND   = 4;
    localparam int W    = 4 * ND;
    localparam int MAXC = 10000;

    logic         clk;
    logic         reset;
    logic         tick;
    logic         startStop;
    logic         clear;
    logic         lap;
    logic [W-1:0] display;
    logic         running;
    logic         lapActive;
    logic         carryOut;

    int checks = 0;
    int errors = 0;

    stopwatch_sequencer #(.NUM_DIGITS(ND)) dut (
        .clockIn   (clk),
        .reset     (reset),
        .tick      (tick),
        .startStop (startStop),
        .clear     (clear),
        .lap       (lap),
        .display   (display),
        .running   (running),
        .lapActive (lapActive),
        .carryOut  (carryOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (decimal integers) ----------------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_t;

    mstate_t m_state;
    int      m_count;
    int      m_lap;
    bit      m_lact;
    bit      m_carry;
    bit      h_ss, h_clr, h_lap;

    typedef struct {
        logic [W-1:0] disp;
        logic         run;
        logic         lact;
        logic         carry;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < ND; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_count = 0;
        m_lap   = 0;
        m_lact  = 0;
        m_carry = 0;
        h_ss    = 1;
        h_clr   = 1;
        h_lap   = 1;
    endtask

    task automatic model_step(input bit t, input bit s, input bit c, input bit l);
        bit ps, pc, pl, qual;
        exp_t e;
        ps = s && !h_ss;
        pc = c && !h_clr;
        pl = l && !h_lap;
        h_ss = s; h_clr = c; h_lap = l;
        qual = (m_state == M_RUN) && t;
        m_carry = qual && (m_count == MAXC - 1);
        case (m_state)
            M_IDLE: if (ps) m_state = M_RUN;
            M_RUN: begin
                if (ps) m_state = M_PAUSE;
                else if (pl) begin
                    if (!m_lact) begin m_lap = m_count; m_lact = 1; end
                    else m_lact = 0;
                end
            end
            default: begin
                if (pc) begin
                    m_state = M_IDLE; m_count = 0; m_lap = 0; m_lact = 0;
                end else if (ps) m_state = M_RUN;
                else if (pl) m_lact = 0;
            end
        endcase
        if (qual) m_count = (m_count + 1) % MAXC;
        e.disp  = m_lact ? to_bcd(m_lap) : to_bcd(m_count);
        e.run   = (m_state == M_RUN);
        e.lact  = m_lact;
        e.carry = m_carry;
        sb_q.push_back(e);
    endtask

    // Called at negedge+1: drive inputs, push expectation, return at the
    // next negedge+1 with post-edge outputs settled and already scored.
    task automatic drive(input bit t, input bit s, input bit c, input bit l);
        tick = t; startStop = s; clear = c; lap = l;
        model_step(t, s, c, l);
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expectation per clock edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            if (display !== e.disp || running !== e.run ||
                lapActive !== e.lact || carryOut !== e.carry) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got disp=%h run=%b lap=%b carry=%b, expected disp=%h run=%b lap=%b carry=%b",
                         $time, display, running, lapActive, carryOut,
                         e.disp, e.run, e.lact, e.carry);
            end
        end
    end

    // ---------------------------- tests ---------------------------------
    task automatic test_reset();
        checks++;
        if (display !== 16'h0000 || running !== 1'b0 || lapActive !== 1'b0 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: disp=%h run=%b lap=%b carry=%b, expected 0000/0/0/0",
                     display, running, lapActive, carryOut);
        end
        $display("reset state: disp=%h run=%b", display, running);
    endtask

    task automatic test_start_and_count();
        repeat (3) drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL idle_ticks: disp=%h run=%b, expected 0000/0", display, running);
        end
        drive(1, 1, 0, 0);
        checks++;
        if (display !== 16'h0000 || running !== 1'b1) begin
            errors++;
            $display("FAIL start_same_tick: disp=%h run=%b, expected 0000/1", display, running);
        end
        drive(0, 0, 0, 0);
        repeat (12) drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0012) begin
            errors++;
            $display("FAIL count_12: disp=%h, expected 0012", display);
        end
        $display("start and count: disp=%h run=%b", display, running);
    endtask

    // From RUN: pause, clear, restart so the count is 0 and running.
    task automatic restart_from_zero();
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        drive(0, 0, 1, 0); drive(0, 0, 0, 0);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
    endtask

    task automatic test_cascade();
        restart_from_zero();
        repeat (9) drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0010) begin
            errors++;
            $display("FAIL carry_9_to_10: disp=%h, expected 0010", display);
        end
        repeat (89) drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0100) begin
            errors++;
            $display("FAIL carry_99_to_100: disp=%h, expected 0100", display);
        end
        repeat (9899) drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h9999 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL reach_9999: disp=%h carry=%b, expected 9999/0", display, carryOut);
        end
        drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0000 || carryOut !== 1'b1) begin
            errors++;
            $display("FAIL rollover: disp=%h carry=%b, expected 0000/1", display, carryOut);
        end
        drive(0, 0, 0, 0);
        checks++;
        if (carryOut !== 1'b0) begin
            errors++;
            $display("FAIL carry_one_cycle: carry=%b, expected 0", carryOut);
        end
        $display("cascade rollover: disp=%h carry=%b", display, carryOut);
    endtask

    task automatic test_lap();
        repeat (25) drive(1, 0, 0, 0);
        drive(1, 0, 0, 1);
        checks++;
        if (lapActive !== 1'b1 || display !== 16'h0025) begin
            errors++;
            $display("FAIL lap_capture: disp=%h lap=%b, expected 0025/1", display, lapActive);
        end
        repeat (4) drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0025) begin
            errors++;
            $display("FAIL lap_frozen: disp=%h, expected 0025", display);
        end
        drive(0, 0, 0, 1);
        checks++;
        if (lapActive !== 1'b0 || display !== 16'h0030) begin
            errors++;
            $display("FAIL lap_release: disp=%h lap=%b, expected 0030/0", display, lapActive);
        end
        drive(0, 0, 0, 0);
        $display("lap: disp=%h lap=%b", display, lapActive);
    endtask

    task automatic test_hold_through_reset();
        startStop = 1;
        reset = 1;
        model_reset();
        @(negedge clk); #1;
        @(negedge clk); #1;
        reset = 0;
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL held_button_no_press: run=%b, expected 0", running);
        end
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL press_after_release: run=%b, expected 1", running);
        end
        drive(0, 0, 0, 0);
        repeat (3) drive(1, 0, 0, 0);
        // startStop and clear together in RUN, with a tick: pause only,
        // and the tick on the edge leaving RUN is counted.
        drive(1, 1, 1, 0);
        checks++;
        if (running !== 1'b0 || display !== 16'h0004) begin
            errors++;
            $display("FAIL ss_clear_priority: disp=%h run=%b, expected 0004/0", display, running);
        end
        drive(0, 0, 0, 0);
        $display("hold through reset: disp=%h run=%b", display, running);
    endtask

    task automatic test_clear();
        drive(1, 1, 0, 0);
        checks++;
        if (display !== 16'h0004 || running !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick_ignored: disp=%h run=%b, expected 0004/1", display, running);
        end
        drive(0, 0, 0, 0);
        repeat (38) drive(1, 0, 0, 0);
        drive(0, 0, 0, 1); drive(0, 0, 0, 0);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        checks++;
        if (display !== 16'h0042 || lapActive !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_with_lap: disp=%h lap=%b run=%b, expected 0042/1/0", display, lapActive, running);
        end
        drive(0, 0, 1, 0);
        checks++;
        if (display !== 16'h0000 || lapActive !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_pause: disp=%h lap=%b run=%b, expected 0000/0/0", display, lapActive, running);
        end
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0); drive(0, 0, 0, 0);
        repeat (5) drive(1, 0, 0, 0);
        drive(1, 0, 1, 0);
        checks++;
        if (display !== 16'h0006 || running !== 1'b1) begin
            errors++;
            $display("FAIL clear_in_run_ignored: disp=%h run=%b, expected 0006/1", display, running);
        end
        drive(0, 0, 0, 0);
        $display("clear: disp=%h run=%b", display, running);
    endtask

    task automatic test_async_reset();
        repeat (311) drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0317) begin
            errors++;
            $display("FAIL reach_0317: disp=%h, expected 0317", display);
        end
        tick = 1;
        #2;
        reset = 1;
        #1;
        checks++;
        if (display !== 16'h0000 || running !== 1'b0 || lapActive !== 1'b0 || carryOut !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: disp=%h run=%b lap=%b carry=%b, expected 0000/0/0/0",
                     display, running, lapActive, carryOut);
        end
        model_reset();
        @(negedge clk); #1;
        tick = 0;
        reset = 0;
        drive(1, 0, 0, 0);
        checks++;
        if (display !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: disp=%h run=%b, expected 0000/0", display, running);
        end
        $display("async reset: disp=%h run=%b", display, running);
    endtask

    initial begin
        reset = 1; tick = 0; startStop = 0; clear = 0; lap = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset = 0;
        test_reset();
        test_start_and_count();
        test_cascade();
        test_lap();
        test_hold_through_reset();
        test_clear();
        test_async_reset();
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
